// File: rtl/hamming_tx.sv
// Hamming(7,4)+overall-parity (SECDED) encoder with optional single-bit error
// injection, parallel codeword output and a framed LSB-first serial transmitter.
module hamming_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] data_in,
    input  logic       err_en,
    input  logic [2:0] err_pos,
    output logic [7:0] cw_out,
    output logic       cw_valid,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state, state_n;
    logic [BAUD_W-1:0] baud, baud_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [7:0]        shreg, shreg_n;
    logic [7:0]        cw_n;
    logic              cw_valid_n;
    logic              tx_done_n;
    logic              tx_serial_n;
    logic              baud_last;
    logic [7:0]        cw_enc;

    // Parity is computed on the clean codeword, so any injected flip yields odd total parity.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] c;
        c    = 8'h00;
        c[3] = d[3];
        c[5] = d[2];
        c[6] = d[1];
        c[7] = d[0];
        c[1] = c[3] ^ c[5] ^ c[7];
        c[2] = c[3] ^ c[6] ^ c[7];
        c[4] = c[5] ^ c[6] ^ c[7];
        c[0] = ^c[7:1];
        return c;
    endfunction

    always_comb begin
        cw_enc = encode(data_in);
        if (err_en) begin
            cw_enc = cw_enc ^ (8'(1) << err_pos);
        end
    end

    assign baud_last = (baud == BAUD_LAST);

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            cw_out    <= 8'h00;
            cw_valid  <= 1'b0;
            tx_done   <= 1'b0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_n;
            baud      <= baud_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            cw_out    <= cw_n;
            cw_valid  <= cw_valid_n;
            tx_done   <= tx_done_n;
            tx_serial <= tx_serial_n;
            tx_busy   <= (state_n != IDLE);
            in_ready  <= (state_n == IDLE);
        end
    end

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_n     = state;
        baud_n      = baud;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        cw_n        = cw_out;
        cw_valid_n  = 1'b0;
        tx_done_n   = 1'b0;
        tx_serial_n = 1'b1;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    cw_n       = cw_enc;
                    shreg_n    = cw_enc;
                    cw_valid_n = 1'b1;
                    baud_n     = '0;
                    bit_idx_n  = 3'd0;
                    state_n    = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = 3'd0;
                        state_n   = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                    end
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n    = '0;
                    tx_done_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
            end
        endcase

        // Line level follows the state being entered so it lines up with the registered state.
        case (state_n)
            START:   tx_serial_n = 1'b0;
            DATA:    tx_serial_n = shreg_n[0];
            default: tx_serial_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_hamming_tx.sv
// Directed bench for hamming_tx: encode table, frame timing, error injection,
// asynchronous reset mid-frame and back-to-back framing at one clock per bit.
module tb_hamming_tx;

    localparam int unsigned CPB4 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       v4 = 1'b0, e4 = 1'b0;
    logic [3:0] d4 = 4'h0;
    logic [2:0] p4 = 3'd0;
    logic       ready4, cwv4, ser4, busy4, done4;
    logic [7:0] cw4;

    logic       v1 = 1'b0, e1 = 1'b0;
    logic [3:0] d1 = 4'h0;
    logic [2:0] p1 = 3'd0;
    logic       ready1, cwv1, ser1, busy1, done1;
    logic [7:0] cw1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hamming_tx #(.CLKS_PER_BIT(CPB4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ready4), .data_in(d4),
        .err_en(e4), .err_pos(p4), .cw_out(cw4), .cw_valid(cwv4),
        .tx_serial(ser4), .tx_busy(busy4), .tx_done(done4)
    );

    hamming_tx #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ready1), .data_in(d1),
        .err_en(e1), .err_pos(p1), .cw_out(cw1), .cw_valid(cwv1),
        .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready4();
        int k;
        k = 0;
        while (!ready4 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!ready4) chk("ready4_timeout", 64'(ready4), 64'd1);
    endtask

    // One CPB=4 frame, sampled at every cycle from the accept edge to the return to IDLE.
    task automatic run_frame4(input string tag, input logic [3:0] d, input logic en,
                              input logic [2:0] pos, input logic [7:0] exp_cw);
        logic [40:0] s_ser, s_busy, s_vld, s_done, s_rdy;
        logic [40:0] x_ser, x_busy, x_vld, x_done, x_rdy;
        int q;
        wait_ready4();
        d4 = d; e4 = en; p4 = pos; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0; d4 = ~d; e4 = ~en; p4 = ~pos;
        chk({tag, ".cw"}, 64'(cw4), 64'(exp_cw));
        for (int n = 0; n <= 40; n++) begin
            s_ser[n]  = ser4;
            s_busy[n] = busy4;
            s_vld[n]  = cwv4;
            s_done[n] = done4;
            s_rdy[n]  = ready4;
            if (n < 40) begin
                @(posedge clk); #1;
            end
        end
        for (int n = 0; n <= 40; n++) begin
            q = (n - int'(CPB4)) / int'(CPB4);
            if (n < int'(CPB4))          x_ser[n] = 1'b0;
            else if (n < 9 * int'(CPB4)) x_ser[n] = exp_cw[q];
            else                         x_ser[n] = 1'b1;
            x_busy[n] = (n < 40);
            x_vld[n]  = (n == 0);
            x_done[n] = (n == 40);
            x_rdy[n]  = (n == 40);
        end
        chk({tag, ".serial"}, 64'(s_ser),  64'(x_ser));
        chk({tag, ".busy"},   64'(s_busy), 64'(x_busy));
        chk({tag, ".cwvalid"},64'(s_vld),  64'(x_vld));
        chk({tag, ".done"},   64'(s_done), 64'(x_done));
        chk({tag, ".ready"},  64'(s_rdy),  64'(x_rdy));
        chk({tag, ".hold"},   64'(cw4),    64'(exp_cw));
    endtask

    logic [7:0] enc_tab [16] = '{8'h00, 8'h96, 8'h55, 8'hC3, 8'h33, 8'hA5, 8'h66, 8'hF0,
                                 8'h0F, 8'h99, 8'h5A, 8'hCC, 8'h3C, 8'hAA, 8'h69, 8'hFF};

    initial begin
        int         acc_n, viol;
        int         acc_t [4];
        logic [7:0] acc_cw [4];
        logic [10:0] s1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset4", 64'({ser4, ready4, busy4, cwv4, done4, cw4}), 64'({5'b11000, 8'h00}));
        chk("reset1", 64'({ser1, ready1, busy1, cwv1, done1, cw1}), 64'({5'b11000, 8'h00}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_frame4($sformatf("enc%0d", i), 4'(i), 1'b0, 3'd5, enc_tab[i]);
        end

        run_frame4("err5", 4'b1011, 1'b1, 3'd5, 8'hEC);
        chk("err5.parity", 64'(^cw4), 64'd1);
        run_frame4("err0", 4'b1011, 1'b1, 3'd0, 8'hCD);
        chk("err0.parity", 64'(^cw4), 64'd1);

        // Asynchronous reset while bit 3 of the data phase is on the line.
        wait_ready4();
        d4 = 4'b1011; e4 = 1'b0; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("mid.busy", 64'(busy4), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.reset", 64'({ser4, ready4, busy4, cwv4, done4, cw4}), 64'({5'b11000, 8'h00}));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk("mid.idle", 64'({ser4, busy4, ready4}), 64'(3'b101));
        end
        run_frame4("mid.after", 4'b1011, 1'b0, 3'd0, 8'hCC);

        // Back-to-back at one clock per bit with in_valid held high.
        acc_n = 0;
        viol  = 0;
        s1    = '0;
        acc_t = '{0, 0, 0, 0};
        d1 = 4'b0001; e1 = 1'b0; v1 = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (cwv1) begin
                if (acc_n < 4) begin
                    acc_t[acc_n]  = t;
                    acc_cw[acc_n] = cw1;
                end
                acc_n++;
                d1 = (acc_n == 1) ? 4'hF : 4'h0;
                e1 = (acc_n == 1);
                p1 = 3'd2;
                e1 = 1'b0;
            end
            if (busy1 && ready1) viol++;
            if (acc_n >= 1 && (t - acc_t[0]) <= 10) s1[t - acc_t[0]] = ser1;
        end
        v1 = 1'b0;
        chk("b2b.count", 64'(acc_n), 64'd4);
        chk("b2b.gap1",  64'(acc_t[1] - acc_t[0]), 64'd11);
        chk("b2b.gap2",  64'(acc_t[2] - acc_t[1]), 64'd11);
        chk("b2b.cw0",   64'(acc_cw[0]), 64'h96);
        chk("b2b.cw1",   64'(acc_cw[1]), 64'hFF);
        chk("b2b.cw2",   64'(acc_cw[2]), 64'h00);
        chk("b2b.ready_in_frame", 64'(viol), 64'd0);
        chk("b2b.serial", 64'(s1), 64'({2'b11, 8'h96, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
